// File: rtl/accum_table_read_control.sv
// Read-side sequencer for the accumulator table: walks stripe-major addresses
// one read per cycle under downstream backpressure and tags each result row.
module accum_table_read_control #(
    parameter int unsigned MAX_OUT_ROWS = 128,
    parameter int unsigned MAX_OUT_COLS = 128,
    parameter int unsigned SYS_ARR_ROWS = 16,
    parameter int unsigned SYS_ARR_COLS = 16,
    localparam int unsigned NUM_SUBMATS_N  = MAX_OUT_COLS / SYS_ARR_COLS,
    localparam int unsigned NUM_ACCUM_ROWS = MAX_OUT_ROWS * NUM_SUBMATS_N,
    localparam int unsigned AW = $clog2(NUM_ACCUM_ROWS),
    localparam int unsigned RW = $clog2(MAX_OUT_ROWS),
    localparam int unsigned NW = $clog2(NUM_SUBMATS_N)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_start,
    input  logic [RW:0]   i_num_rows,
    input  logic [NW:0]   i_num_submats_n,
    input  logic          i_out_ready,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr,
    output logic          o_out_valid,
    output logic [RW-1:0] o_wb_row,
    output logic [NW-1:0] o_wb_submat_n,
    output logic          o_busy,
    output logic          o_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } state_t;

    localparam logic [AW-1:0] ROWS_AW = AW'(MAX_OUT_ROWS);

    state_t        r_state;
    state_t        w_next_state;

    logic [RW:0]   r_num_rows;
    logic [NW:0]   r_num_submats_n;
    logic [RW-1:0] r_row;
    logic [NW:0]   r_n;

    logic          r_out_valid;
    logic [RW-1:0] r_wb_row;
    logic [NW-1:0] r_wb_submat_n;

    logic          w_accept;
    logic          w_zero_size;
    logic          w_rd_en;
    logic          w_last_row;
    logic          w_last_entry;
    logic [AW-1:0] w_rd_addr;

    assign w_accept     = (r_state == S_IDLE) && i_start;
    assign w_zero_size  = (i_num_rows == '0) || (i_num_submats_n == '0);
    assign w_rd_en      = (r_state == S_READ) && i_out_ready;
    assign w_last_row   = ({1'b0, r_row} == (r_num_rows - (RW+1)'(1)));
    assign w_last_entry = w_last_row && (r_n == (r_num_submats_n - (NW+1)'(1)));

    // Same stripe-major layout as the write side: stripe n occupies a block of MAX_OUT_ROWS entries.
    assign w_rd_addr = (AW'(r_n) * ROWS_AW) + AW'(r_row);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = w_zero_size ? S_DRAIN : S_READ;
                end
            end
            S_READ: begin
                if (w_rd_en && w_last_entry) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_num_rows      <= '0;
            r_num_submats_n <= '0;
            r_row           <= '0;
            r_n             <= '0;
        end else if (w_accept) begin
            r_num_rows      <= i_num_rows;
            r_num_submats_n <= i_num_submats_n;
            r_row           <= '0;
            r_n             <= '0;
        end else if (w_rd_en) begin
            if (w_last_row) begin
                r_row <= '0;
                r_n   <= r_n + (NW+1)'(1);
            end else begin
                r_row <= r_row + RW'(1);
            end
        end
    end

    // Tags trail the read by the table's one-cycle latency.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_out_valid   <= 1'b0;
            r_wb_row      <= '0;
            r_wb_submat_n <= '0;
        end else begin
            r_out_valid   <= w_rd_en;
            r_wb_row      <= r_row;
            r_wb_submat_n <= r_n[NW-1:0];
        end
    end

    assign o_rd_en       = w_rd_en;
    assign o_rd_addr     = w_rd_addr;
    assign o_out_valid   = r_out_valid;
    assign o_wb_row      = r_wb_row;
    assign o_wb_submat_n = r_wb_submat_n;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_DRAIN);

endmodule
